// File: rtl/wb_load_if.sv
// wb_load_if: MEM/WB fields and memory response into writeback, regfile write port and stall out.
interface wb_load_if;
    logic [31:0] pc_i, instruction_i, alu_data_i, rt_data_i, mem_addr_i, rdata_i;
    logic [4:0]  regfile_waddr_i, rf_waddr_o;
    logic        regfile_wen_i, mem_to_reg_i, rdata_valid_i;
    logic        data_stall_o, rf_wen_o, bus_err_o;
    logic [31:0] rf_wdata_o, wb_pc_o;
    modport slave (
        input  pc_i, instruction_i, regfile_wen_i, regfile_waddr_i, alu_data_i, rt_data_i,
               mem_to_reg_i, mem_addr_i, rdata_i, rdata_valid_i,
        output data_stall_o, rf_wen_o, rf_waddr_o, rf_wdata_o, wb_pc_o, bus_err_o
    );
    modport master (
        output pc_i, instruction_i, regfile_wen_i, regfile_waddr_i, alu_data_i, rt_data_i,
               mem_to_reg_i, mem_addr_i, rdata_i, rdata_valid_i,
        input  data_stall_o, rf_wen_o, rf_waddr_o, rf_wdata_o, wb_pc_o, bus_err_o
    );
endinterface

// File: rtl/wb_load_unit.sv
// wb_load_unit: writeback stage; aligns/extends/merges load data, waits for late data with a watchdog.
module wb_load_unit #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input logic clk,
    input logic rst,
    wb_load_if.slave wb
);
    localparam logic [5:0] OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_LH = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101, OP_LWL = 6'b100010, OP_LWR = 6'b100110;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t state, state_nx;
    logic [31:0] buffer, src, lwl, lwr, load_data, rt;
    logic [CNT_W-1:0] cnt;
    logic [7:0] b;
    logic [15:0] h;
    logic [1:0] a;
    logic [5:0] op;
    logic wen, stall, timeout, bus_err;
    logic unused_bits;
    assign a = wb.mem_addr_i[1:0];
    assign op = wb.instruction_i[31:26];
    assign rt = wb.rt_data_i;
    assign unused_bits = ^{wb.mem_addr_i[31:2], wb.instruction_i[25:0]};
    assign timeout = (cnt == CNT_W'(TIMEOUT));
    // DONE writes from the latched word; IDLE hits take the bus data directly
    always_comb begin
        src = (state == S_DONE) ? buffer : wb.rdata_i;
        b = src[{a, 3'b000} +: 8];
        h = a[1] ? src[31:16] : src[15:0];
        lwl = (a == 2'd0) ? {src[7:0], rt[23:0]} :
              (a == 2'd1) ? {src[15:0], rt[15:0]} :
              (a == 2'd2) ? {src[23:0], rt[7:0]} : src;
        lwr = (a == 2'd0) ? src :
              (a == 2'd1) ? {rt[31:24], src[31:8]} :
              (a == 2'd2) ? {rt[31:16], src[31:16]} : {rt[31:8], src[31:24]};
        load_data = (op == OP_LB)  ? {{24{b[7]}}, b} :
                    (op == OP_LBU) ? {24'b0, b} :
                    (op == OP_LH)  ? {{16{h[15]}}, h} :
                    (op == OP_LHU) ? {16'b0, h} :
                    (op == OP_LWL) ? lwl :
                    (op == OP_LWR) ? lwr : src;
    end
    always_comb begin
        state_nx = state;
        stall = 1'b0;
        wen = 1'b0;
        wb.rf_wdata_o = wb.alu_data_i;
        case (state)
            S_IDLE: begin
                if (!wb.mem_to_reg_i) begin
                    wen = wb.regfile_wen_i;
                end else if (wb.rdata_valid_i) begin
                    wen = wb.regfile_wen_i;
                    wb.rf_wdata_o = load_data;
                end else begin
                    stall = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                state_nx = wb.rdata_valid_i ? S_DONE : timeout ? S_IDLE : S_WAIT;
            end
            default: begin
                wen = wb.regfile_wen_i;
                wb.rf_wdata_o = load_data;
                state_nx = S_IDLE;
            end
        endcase
    end
    assign wb.data_stall_o = stall;
    assign wb.rf_wen_o = wen && (wb.regfile_waddr_i != 5'd0);
    assign wb.rf_waddr_o = wb.regfile_waddr_i;
    assign wb.wb_pc_o = wb.pc_i;
    assign wb.bus_err_o = bus_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            buffer <= '0;
            cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nx;
            bus_err <= (state == S_WAIT) && !wb.rdata_valid_i && timeout;
            cnt <= (state == S_IDLE) ? CNT_W'(1) : cnt + 1'b1;
            if (state == S_WAIT && wb.rdata_valid_i) buffer <= wb.rdata_i;
        end
    end
endmodule
